// File: rtl/mac_bank_seq.sv
// mac_bank_seq: job sequencer for the 12-lane MAC bank.
// It walks a job tile by tile and issues one buffer read per accumulation
// step. The bank's vld_i follows each read by one cycle, and the first step
// of each tile also raises an accumulator-clear flag. After the last step it
// waits for the MAC pipeline to drain, then pulses the output-capture strobe.
// Optional build macro: MAC_BANK_SEQ_PERF_EN adds oStallCnt, a count of the
// RUN cycles during which the buffers were not ready.
module mac_bank_seq #(
  parameter int MAC_LAT = 4,
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic [CNT_W-1:0]  iNumCh,
  input  logic [CNT_W-1:0]  iNumTile,
  input  logic [ADDR_W-1:0] iBaseAddr,
  input  logic              iDataRdy,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oRdAddr,
  output logic              oVld,
  output logic              oAccClr,
  output logic              oOutVld,
  output logic [CNT_W-1:0]  oTileIdx,
  output logic              oBusy,
  output logic              oDone
`ifdef MAC_BANK_SEQ_PERF_EN
  ,
  output logic [15:0]       oStallCnt
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // The drain counter has to hold values 0..MAC_LAT.
  localparam int DRN_W = $clog2(MAC_LAT + 2);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]  tile_q, tile_d;
  logic [CNT_W-1:0]  num_ch_q, num_ch_d;
  logic [CNT_W-1:0]  num_tile_q, num_tile_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic              vld_q, clr_q;
  logic              rd_en;
  logic              start_ok;
  logic              abort_act;
  logic [CNT_W:0]    tile_inc;

  // An abort received in IDLE also blocks a start arriving in the same cycle.
  assign start_ok  = (state_q == S_IDLE) && iStart && !iAbort;
  assign abort_act = iAbort && (state_q != S_IDLE);
  assign tile_inc  = {1'b0, tile_q} + {{CNT_W{1'b0}}, 1'b1};

  // Next-state and counter logic. Tiles are laid out back to back in the
  // buffers, so the address is one running pointer (base + tile*numCh + step).
  // That pointer steps once per issued read, which avoids a multiplier.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    tile_d     = tile_q;
    num_ch_d   = num_ch_q;
    num_tile_d = num_tile_q;
    addr_d     = addr_q;
    drain_d    = drain_q;
    rd_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          num_ch_d   = (iNumCh == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : iNumCh;
          num_tile_d = iNumTile;
          addr_d     = iBaseAddr;
          step_d     = '0;
          tile_d     = '0;
          drain_d    = '0;
          state_d    = (iNumTile == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (iDataRdy) begin
          rd_en  = 1'b1;
          addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (step_q == num_ch_q - {{(CNT_W-1){1'b0}}, 1'b1}) begin
            step_d  = '0;
            state_d = S_DRAIN;
          end else begin
            step_d = step_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRN_W'(MAC_LAT)) begin
          drain_d = '0;
          state_d = S_OUT;
        end else begin
          drain_d = drain_q + {{(DRN_W-1){1'b0}}, 1'b1};
        end
      end
      S_OUT: begin
        if (tile_inc < {1'b0, num_tile_q}) begin
          tile_d  = tile_inc[CNT_W-1:0];
          state_d = S_RUN;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort takes priority over any other transition: no read is issued in
    // the abort cycle, and the partial counters are discarded.
    if (abort_act) begin
      state_d = S_IDLE;
      rd_en   = 1'b0;
      step_d  = '0;
      drain_d = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      tile_q     <= '0;
      num_ch_q   <= '0;
      num_tile_q <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      tile_q     <= tile_d;
      num_ch_q   <= num_ch_d;
      num_tile_q <= num_tile_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
    end
  end

  // Bank strobes lag the read by one cycle to match the buffer read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      vld_q <= rd_en;
      clr_q <= rd_en && (step_q == '0);
    end
  end

`ifdef MAC_BANK_SEQ_PERF_EN
  logic [15:0] stall_q;

  // Saturating count of stalled RUN cycles for the current or most recent job.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state_q == S_RUN) && !iDataRdy && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign oStallCnt = stall_q;
`endif

  assign oRdEn    = rd_en;
  assign oRdAddr  = addr_q;
  assign oVld     = vld_q;
  assign oAccClr  = clr_q;
  assign oOutVld  = (state_q == S_OUT) && !iAbort;
  assign oTileIdx = tile_q;
  assign oBusy    = (state_q != S_IDLE);
  assign oDone    = (state_q == S_DONE) && !iAbort;

endmodule
